// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode-side inputs and EX-side outputs of the ID/EX pipeline register
interface id_ex_stage_if #(
  parameter int STALL_CNT_W = 16
);
  // decode side
  logic                   id_valid;
  logic [31:0]            id_pc;
  logic [31:0]            id_rd1;
  logic [31:0]            id_rd2;
  logic [31:0]            id_imm;
  logic [4:0]             id_rs;
  logic [4:0]             id_rt;
  logic [4:0]             id_rd;
  logic                   id_uses_rt;
  logic [9:0]             id_ctrl;
  logic                   flush;

  // execute side
  logic                   ex_valid;
  logic [31:0]            ex_pc;
  logic [31:0]            ex_rd1;
  logic [31:0]            ex_rd2;
  logic [31:0]            ex_imm;
  logic [4:0]             ex_rs;
  logic [4:0]             ex_rt;
  logic [9:0]             ex_ctrl;
  logic [4:0]             ex_wreg;
  logic                   stall;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_pc, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd,
           id_uses_rt, id_ctrl, flush,
    input  ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_ctrl,
           ex_wreg, stall, stall_count
  );

  modport slave (
    input  id_valid, id_pc, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd,
           id_uses_rt, id_ctrl, flush,
    output ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_ctrl,
           ex_wreg, stall, stall_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall detection and bubble counter
module id_ex_stage #(
  parameter int STALL_CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  id_ex_stage_if.slave   bus
);

  // control bit positions inside id_ctrl / ex_ctrl
  localparam int CTRL_REG_WRITE = 0;
  localparam int CTRL_MEM_READ  = 1;
  localparam int CTRL_MEM_WRITE = 2;
  localparam int CTRL_REG_DST   = 5;

  logic                   ex_valid_q;
  logic [31:0]            ex_pc_q;
  logic [31:0]            ex_rd1_q;
  logic [31:0]            ex_rd2_q;
  logic [31:0]            ex_imm_q;
  logic [4:0]             ex_rs_q;
  logic [4:0]             ex_rt_q;
  logic [9:0]             ex_ctrl_q;
  logic [4:0]             ex_wreg_q;
  logic [STALL_CNT_W-1:0] stall_count_q;

  logic                   rs_match;
  logic                   rt_match;
  logic                   hazard;
  logic                   stall;
  logic                   bubble;
  logic [4:0]             id_wreg;
  logic [9:0]             id_ctrl_safe;

  // Load-use detection against the instruction currently in EX. A load to r0
  // never produces a usable value, so it never holds decode.
  always_comb begin
    rs_match = (ex_wreg_q == bus.id_rs);
    rt_match = bus.id_uses_rt && (ex_wreg_q == bus.id_rt);
    hazard   = bus.id_valid && ex_valid_q && ex_ctrl_q[CTRL_MEM_READ] &&
               (ex_wreg_q != 5'd0) && (rs_match || rt_match);
    // A redirect kills the consumer anyway, so there is nothing to hold for.
    stall    = hazard && !bus.flush;
    bubble   = bus.flush || stall;
  end

  // Destination select and side-effect masking for the captured instruction.
  always_comb begin
    id_wreg      = bus.id_ctrl[CTRL_REG_DST] ? bus.id_rd : bus.id_rt;
    id_ctrl_safe = bus.id_ctrl;
    if (!bus.id_valid) begin
      id_ctrl_safe[CTRL_MEM_WRITE:CTRL_REG_WRITE] = 3'b000;
    end
  end

  // Pipeline register: bubble on flush or stall, otherwise capture decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_pc_q    <= 32'd0;
      ex_rd1_q   <= 32'd0;
      ex_rd2_q   <= 32'd0;
      ex_imm_q   <= 32'd0;
      ex_rs_q    <= 5'd0;
      ex_rt_q    <= 5'd0;
      ex_ctrl_q  <= 10'd0;
      ex_wreg_q  <= 5'd0;
    end else if (bubble) begin
      ex_valid_q <= 1'b0;
      ex_pc_q    <= 32'd0;
      ex_rd1_q   <= 32'd0;
      ex_rd2_q   <= 32'd0;
      ex_imm_q   <= 32'd0;
      ex_rs_q    <= 5'd0;
      ex_rt_q    <= 5'd0;
      ex_ctrl_q  <= 10'd0;
      ex_wreg_q  <= 5'd0;
    end else begin
      ex_valid_q <= bus.id_valid;
      ex_pc_q    <= bus.id_pc;
      ex_rd1_q   <= bus.id_rd1;
      ex_rd2_q   <= bus.id_rd2;
      ex_imm_q   <= bus.id_imm;
      ex_rs_q    <= bus.id_rs;
      ex_rt_q    <= bus.id_rt;
      ex_ctrl_q  <= id_ctrl_safe;
      ex_wreg_q  <= id_wreg;
    end
  end

  // Saturating count of load-use bubbles; flush-won cycles are not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else if (stall && (stall_count_q != {STALL_CNT_W{1'b1}})) begin
      stall_count_q <= stall_count_q + STALL_CNT_W'(1);
    end
  end

  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_pc       = ex_pc_q;
  assign bus.ex_rd1      = ex_rd1_q;
  assign bus.ex_rd2      = ex_rd2_q;
  assign bus.ex_imm      = ex_imm_q;
  assign bus.ex_rs       = ex_rs_q;
  assign bus.ex_rt       = ex_rt_q;
  assign bus.ex_ctrl     = ex_ctrl_q;
  assign bus.ex_wreg     = ex_wreg_q;
  assign bus.stall       = stall;
  assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - vector table and scoreboard bench for id_ex_stage
module tb_id_ex_stage;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        uses_rt;
    logic [9:0]  ctrl;
    logic        flush;
    logic        exp_stall;
    int          exp_cnt;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [9:0]  ctrl;
    logic [4:0]  wreg;
    int          cnt;
  } exp_t;

  localparam logic [9:0] C_ALU  = 10'h021;
  localparam logic [9:0] C_LOAD = 10'h00B;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] id_pc = '0, id_rd1 = '0, id_rd2 = '0, id_imm = '0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic        id_uses_rt = 1'b0;
  logic [9:0]  id_ctrl = '0;
  logic        flush = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  exp_t exp_q[$];
  vec_t tbl[21];

  always #5 clk = ~clk;

  id_ex_stage_if #(.STALL_CNT_W(16)) bus16 ();
  id_ex_stage_if #(.STALL_CNT_W(2))  bus2 ();

  assign bus16.id_valid = id_valid;    assign bus2.id_valid = id_valid;
  assign bus16.id_pc = id_pc;          assign bus2.id_pc = id_pc;
  assign bus16.id_rd1 = id_rd1;        assign bus2.id_rd1 = id_rd1;
  assign bus16.id_rd2 = id_rd2;        assign bus2.id_rd2 = id_rd2;
  assign bus16.id_imm = id_imm;        assign bus2.id_imm = id_imm;
  assign bus16.id_rs = id_rs;          assign bus2.id_rs = id_rs;
  assign bus16.id_rt = id_rt;          assign bus2.id_rt = id_rt;
  assign bus16.id_rd = id_rd;          assign bus2.id_rd = id_rd;
  assign bus16.id_uses_rt = id_uses_rt; assign bus2.id_uses_rt = id_uses_rt;
  assign bus16.id_ctrl = id_ctrl;      assign bus2.id_ctrl = id_ctrl;
  assign bus16.flush = flush;          assign bus2.flush = flush;

  id_ex_stage #(.STALL_CNT_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  id_ex_stage #(.STALL_CNT_W(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic urt, input logic [9:0] c,
                              input logic fl, input logic es, input int ec);
    vec_t t;
    t.valid = v; t.rs = rs; t.rt = rt; t.rd = rd; t.uses_rt = urt; t.ctrl = c;
    t.flush = fl; t.exp_stall = es; t.exp_cnt = ec;
    t.pc = $urandom; t.rd1 = $urandom; t.rd2 = $urandom; t.imm = $urandom;
    return t;
  endfunction

  task automatic set_inputs(input vec_t v);
    id_valid = v.valid; id_pc = v.pc; id_rd1 = v.rd1; id_rd2 = v.rd2; id_imm = v.imm;
    id_rs = v.rs; id_rt = v.rt; id_rd = v.rd; id_uses_rt = v.uses_rt;
    id_ctrl = v.ctrl; flush = v.flush;
  endtask

  // Apply one vector for one cycle; push the expected EX contents, pop and compare after the edge.
  task automatic drive(input vec_t v, input string tag);
    exp_t e;
    exp_t g;
    int   c2;
    @(negedge clk);
    set_inputs(v);
    #1;
    check({tag, " stall w16"}, 32'(bus16.stall), 32'(v.exp_stall));
    check({tag, " stall w2"}, 32'(bus2.stall), 32'(v.exp_stall));
    if (v.flush || v.exp_stall) begin
      e = '{valid: 1'b0, pc: '0, rd1: '0, rd2: '0, imm: '0, rs: '0, rt: '0,
            ctrl: '0, wreg: '0, cnt: v.exp_cnt};
    end else begin
      e.valid = v.valid; e.pc = v.pc; e.rd1 = v.rd1; e.rd2 = v.rd2; e.imm = v.imm;
      e.rs = v.rs; e.rt = v.rt;
      e.ctrl = v.valid ? v.ctrl : (v.ctrl & 10'h3F8);
      e.wreg = v.ctrl[5] ? v.rd : v.rt;
      e.cnt = v.exp_cnt;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    g = exp_q.pop_front();
    check({tag, " ex_valid"}, 32'(bus16.ex_valid), 32'(g.valid));
    check({tag, " ex_pc"}, bus16.ex_pc, g.pc);
    check({tag, " ex_rd1"}, bus16.ex_rd1, g.rd1);
    check({tag, " ex_rd2"}, bus16.ex_rd2, g.rd2);
    check({tag, " ex_imm"}, bus16.ex_imm, g.imm);
    check({tag, " ex_rs"}, 32'(bus16.ex_rs), 32'(g.rs));
    check({tag, " ex_rt"}, 32'(bus16.ex_rt), 32'(g.rt));
    check({tag, " ex_ctrl"}, 32'(bus16.ex_ctrl), 32'(g.ctrl));
    check({tag, " ex_wreg"}, 32'(bus16.ex_wreg), 32'(g.wreg));
    check({tag, " stall_count w16"}, 32'(bus16.stall_count), 32'(g.cnt));
    c2 = (g.cnt > 3) ? 3 : g.cnt;
    check({tag, " stall_count w2"}, 32'(bus2.stall_count), 32'(c2));
    check({tag, " ex_wreg w2"}, 32'(bus2.ex_wreg), 32'(g.wreg));
  endtask

  initial begin
    //           valid rs  rt  rd  urt ctrl           flush stall cnt
    tbl[0]  = mk(1'b1, 1,  2,  5,  1, C_ALU,         1'b0, 1'b0, 0);
    tbl[1]  = mk(1'b1, 3,  8,  0,  0, C_LOAD,        1'b0, 1'b0, 0);
    tbl[2]  = mk(1'b1, 8,  9,  10, 1, C_ALU,         1'b0, 1'b1, 1);
    tbl[3]  = tbl[2]; tbl[3].exp_stall = 1'b0;
    tbl[4]  = mk(1'b1, 0,  8,  0,  0, C_LOAD,        1'b0, 1'b0, 1);
    tbl[5]  = mk(1'b1, 4,  8,  11, 0, C_ALU,         1'b0, 1'b0, 1);
    tbl[6]  = mk(1'b1, 0,  8,  0,  0, C_LOAD,        1'b0, 1'b0, 1);
    tbl[7]  = mk(1'b1, 4,  8,  12, 1, C_ALU,         1'b0, 1'b1, 2);
    tbl[8]  = tbl[7]; tbl[8].exp_stall = 1'b0;
    tbl[9]  = mk(1'b1, 0,  8,  0,  0, C_LOAD,        1'b0, 1'b0, 2);
    tbl[10] = mk(1'b1, 8,  1,  3,  1, C_ALU,         1'b1, 1'b0, 2);
    tbl[11] = mk(1'b1, 1,  0,  0,  0, C_LOAD,        1'b0, 1'b0, 2);
    tbl[12] = mk(1'b1, 0,  0,  13, 1, C_ALU,         1'b0, 1'b0, 2);
    tbl[13] = mk(1'b0, 0,  0,  14, 1, 10'h3FF,       1'b0, 1'b0, 2);
    tbl[14] = mk(1'b1, 0,  8,  0,  0, C_LOAD,        1'b0, 1'b0, 2);
    tbl[15] = mk(1'b0, 8,  2,  15, 1, C_ALU,         1'b0, 1'b0, 2);
    tbl[16] = mk(1'b1, 0,  8,  0,  0, C_LOAD,        1'b0, 1'b0, 2);
    tbl[17] = mk(1'b1, 8,  9,  0,  0, C_LOAD,        1'b0, 1'b1, 3);
    tbl[18] = tbl[17]; tbl[18].exp_stall = 1'b0;
    tbl[19] = mk(1'b1, 9,  1,  16, 1, C_ALU,         1'b0, 1'b1, 4);
    tbl[20] = tbl[19]; tbl[20].exp_stall = 1'b0;
    tbl[0].rd1 = 32'h11; tbl[0].rd2 = 32'h22;

    // reset state, checked before any clock edge
    #2;
    check("reset ex_valid", 32'(bus16.ex_valid), 32'd0);
    check("reset ex_ctrl", 32'(bus16.ex_ctrl), 32'd0);
    check("reset ex_wreg", 32'(bus16.ex_wreg), 32'd0);
    check("reset stall", 32'(bus16.stall), 32'd0);
    check("reset stall_count", 32'(bus16.stall_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i], $sformatf("vec%0d", i));
    end

    // asynchronous reset in the middle of a stall
    @(negedge clk);
    set_inputs(mk(1'b1, 0, 8, 0, 0, C_LOAD, 1'b0, 1'b0, 0));
    @(posedge clk);
    @(negedge clk);
    set_inputs(mk(1'b1, 8, 3, 20, 1, C_ALU, 1'b0, 1'b0, 0));
    #1;
    check("midrst stall before", 32'(bus16.stall), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst ex_valid", 32'(bus16.ex_valid), 32'd0);
    check("midrst ex_ctrl", 32'(bus16.ex_ctrl), 32'd0);
    check("midrst ex_wreg", 32'(bus16.ex_wreg), 32'd0);
    check("midrst ex_rd1", bus16.ex_rd1, 32'd0);
    check("midrst ex_pc", bus16.ex_pc, 32'd0);
    check("midrst stall", 32'(bus16.stall), 32'd0);
    check("midrst stall_count", 32'(bus16.stall_count), 32'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("postrst ex_valid", 32'(bus16.ex_valid), 32'd1);
    check("postrst ex_wreg", 32'(bus16.ex_wreg), 32'd20);
    check("postrst ex_ctrl", 32'(bus16.ex_ctrl), 32'(C_ALU));
    check("postrst stall_count", 32'(bus16.stall_count), 32'd0);

    // five load-use pairs from a fresh count: w2 saturates at 3, w16 keeps counting
    for (int k = 0; k < 5; k++) begin
      vec_t cons;
      drive(mk(1'b1, 0, 8, 0, 0, C_LOAD, 1'b0, 1'b0, k), $sformatf("sat%0d load", k));
      cons = mk(1'b1, 8, 2, 7, 1, C_ALU, 1'b0, 1'b1, k + 1);
      drive(cons, $sformatf("sat%0d use", k));
      cons.exp_stall = 1'b0;
      drive(cons, $sformatf("sat%0d retry", k));
    end

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have parameter STALL_CNT_W, default 16, giving the width of the load-use stall counter.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have port id_valid, input, 1, a valid instruction is present in decode.
REQ-005 The block SHALL have ports id_pc, id_rd1, id_rd2 and id_imm, input, 32 each: decode PC, register-file read data for rs and rt, and sign-extended immediate.
REQ-006 The block SHALL have ports id_rs, id_rt and id_rd, input, 5 each: decode register specifiers.
REQ-007 The block SHALL have port id_uses_rt, input, 1, the decode instruction reads rt as a source.
REQ-008 The block SHALL have port id_ctrl, input, 10, decode controls: [0] reg_write, [1] mem_read, [2] mem_write, [3] mem_to_reg, [4] alu_src, [5] reg_dst, [9:6] alu_op.
REQ-009 The block SHALL have port flush, input, 1, branch/jump redirect from EX that kills the decode instruction.
REQ-010 The block SHALL have outputs ex_valid (1), ex_pc, ex_rd1, ex_rd2 and ex_imm (32 each), ex_rs and ex_rt (5 each), and ex_ctrl (10): registered copies of the decode fields.
REQ-011 The block SHALL have output ex_wreg, 5, destination register: id_rd when reg_dst=1, else id_rt, registered.
REQ-012 The block SHALL have output stall, 1, combinational hold request to the PC and IF/ID registers.
REQ-013 The block SHALL have output stall_count, STALL_CNT_W, saturating count of load-use bubbles.

Function
REQ-014 The block SHALL drive load-use hazard = id_valid & ex_valid & ex_ctrl[1] & (ex_wreg!=0) & ((ex_wreg==id_rs) | (id_uses_rt & ex_wreg==id_rt)).
REQ-015 The block SHALL drive stall = hazard & ~flush, combinationally in the same cycle.
REQ-016 On a posedge with flush=1, the block SHALL load a bubble: ex_valid=0, ex_ctrl=0, and all data and register fields 0.
REQ-017 On a posedge with stall=1, the block SHALL load a bubble as in REQ-016 and increment stall_count by 1.
REQ-018 stall_count SHALL saturate at all-ones and never wrap to 0.
REQ-019 Otherwise, the block SHALL capture all id_* fields into ex_* with a latency of 1 cycle and set ex_valid=id_valid.
REQ-020 When id_valid=0 on a capture, the block SHALL force ex_ctrl[2:0]=0 so no architectural side effects propagate.
REQ-021 A hazard SHALL last exactly one cycle for a single load, because the bubble clears ex_ctrl[1]; back-to-back loads SHALL each produce at most one bubble.
REQ-022 When flush and hazard are both asserted, flush SHALL take priority: stall=0 and stall_count unchanged.
REQ-023 A load whose destination is register 0 SHALL never cause a stall.
REQ-024 No forwarding SHALL be performed here; the register file writes on negedge, so the same-cycle WB-to-ID read is already correct.

Reset
REQ-025 While rst_n=0, the block SHALL immediately hold ex_valid, ex_ctrl, ex_wreg, all ex_* data fields, and stall_count at 0.
REQ-026 While rst_n=0, stall SHALL be 0, since ex_valid=0.
REQ-027 An rst_n assertion mid-stall SHALL discard the stalled state; after release, the first posedge SHALL capture normally.

Verification
REQ-028 Scenario: id_valid=1, id_rd1=0x11, id_rd2=0x22, id_ctrl=0x021, id_rd=5 -> one cycle later ex_rd1=0x11, ex_rd2=0x22, ex_wreg=5, ex_valid=1.
REQ-029 Scenario: load with ex_wreg=8, then decode id_rs=8 -> stall=1 for one cycle, next ex_valid=0 and ex_ctrl=0, stall_count=1, then the consumer is captured.
REQ-030 Scenario: load with ex_wreg=8, then decode id_rt=8 with id_uses_rt=0 -> stall=0; with id_uses_rt=1 -> stall=1.
REQ-031 Scenario: hazard and flush asserted together -> stall=0, bubble loaded, stall_count unchanged.
REQ-032 Scenario: STALL_CNT_W=2 with 5 consecutive load-use pairs -> stall_count 1, 2, 3, 3, 3.
REQ-033 Scenario: rst_n pulsed low asynchronously between edges while ex_valid=1 -> all outputs 0 without waiting for clk.
